// File: rtl/online_otf_converter.sv
// online_otf_converter
//   Converts a stream of radix-2 signed digits (borrow-save {d+,d-}, most
//   significant digit first) into a Stage+1-bit two's complement word using
//   on-the-fly conversion. Q and QM (= Q-1) are both kept so every digit
//   is a shift plus a register select, with no carry-propagate adder.
//
// Optional feature macro: ONLINE_OTF_ERRCHK_EN
//   defined   : an accepted 2'b11 digit sets the sticky err flag (cleared by rst)
//   undefined : err is tied low
//   In both builds a 2'b11 digit is converted as 0.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_digit valid this cycle
//   in_digit   in   [1:0] {d+,d-}: 10 = +1, 01 = -1, 00 = 0
//   in_first   in   marks the most significant digit of a word
//   in_ready   out  digit accepted when in_valid && in_ready
//   out_valid  out  out_data holds a completed word
//   out_ready  in   word consumed when out_valid && out_ready
//   out_data   out  [Stage:0] completed word, held until the next completion
//   err        out  sticky illegal-digit flag
//   dbg_state  out  [1:0] FSM state (0 IDLE, 1 ACC, 2 DONE)
//
// Handshake: both ports use valid/ready; a transfer happens on a rising
// clock edge where valid and ready are both high. Valid never depends
// combinationally on ready. in_ready is high in IDLE and ACC, low in DONE.
module online_otf_converter #(
    parameter int Stage = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_digit,
    input  logic             in_first,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Stage:0]   out_data,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int W  = Stage + 1;
    localparam int CW = $clog2(Stage + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    qm_q, qm_d;
    logic [W-1:0]    out_data_q, out_data_d;

    logic            accept;
    logic            dig_pos;
    logic            dig_neg;
    logic [W-1:0]    base_q;
    logic [W-1:0]    base_qm;
    logic [W-1:0]    conv_q;
    logic [W-1:0]    conv_qm;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign dbg_state = state_q;
    assign accept    = in_valid && in_ready;

    // 2'b11 matches neither pattern, so it falls through as a zero digit.
    assign dig_pos = (in_digit == 2'b10);
    assign dig_neg = (in_digit == 2'b01);

    // A first digit starts from Q=0 / QM=-1 regardless of leftover state.
    assign base_q  = in_first ? '0 : q_q;
    assign base_qm = in_first ? '1 : qm_q;

    always_comb begin
        conv_q  = {base_q[W-2:0], 1'b0};
        conv_qm = {base_qm[W-2:0], 1'b1};
        if (dig_pos) begin
            conv_q  = {base_q[W-2:0], 1'b1};
            conv_qm = {base_q[W-2:0], 1'b0};
        end else if (dig_neg) begin
            conv_q  = {base_qm[W-2:0], 1'b1};
            conv_qm = {base_qm[W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        qm_d       = qm_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE, ACC: begin
                // In IDLE only a first digit starts a word; others are dropped.
                // In ACC a first digit aborts the partial word and restarts.
                if (accept && (in_first || state_q == ACC)) begin
                    q_d   = conv_q;
                    qm_d  = conv_qm;
                    cnt_d = in_first ? CW'(1) : CW'(cnt_q + 1'b1);
                    if (cnt_d == CW'(Stage)) begin
                        state_d    = DONE;
                        out_data_d = conv_q;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                // in_ready is low here, so no digit can start alongside the
                // handshake; the next word begins from IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            q_q        <= '0;
            qm_q       <= '1;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            qm_q       <= qm_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef ONLINE_OTF_ERRCHK_EN
    logic err_q, err_d;

    assign err_d = err_q | (accept && (in_digit == 2'b11));
    assign err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
